// File: rtl/serial_bit_streamer_pkg.sv
// Shared definitions for the serial bit streamer and the sequence detectors
// it feeds.
//   state_e : two-state encoding used by the streamer FSM
//   clog2   : ceiling log2, used to size down-counters
package serial_bit_streamer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Smallest number of bits n such that 2**n >= value. Written as a bounded
  // loop so it can be evaluated at elaboration time by any tool.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_bit_streamer_piso.sv
// Parallel-in / serial-out shift register.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset, clears the register
//   load_i     : load data_i (takes priority over shift_en_i)
//   shift_en_i : advance one position toward the emitting end
//   data_i     : parallel word
//   q_o        : current register contents
// MSB_FIRST != 0 shifts left (emitting end is bit WIDTH-1), otherwise
// shifts right (emitting end is bit 0). Vacated positions fill with 0.
module shift_reg_piso
  import serial_bit_streamer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] shifted;

  if (MSB_FIRST != 0) begin : g_left
    assign shifted = {q_q[WIDTH-2:0], 1'b0};
  end else begin : g_right
    assign shifted = {1'b0, q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_en_i) begin
      q_q <= shifted;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_bit_streamer.sv
// Serial bit streamer: takes a parallel word over a valid/ready handshake and
// emits it one bit per clock on x_out, feeding a sequence detector's serial
// input. Back-to-back words are emitted with no idle gap; between frames
// x_out rests at IDLE_BIT.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   load_data   : parallel word, sampled on the accepting edge
//   load_valid  : upstream offers load_data
//   load_ready  : a word can be accepted this cycle (combinational)
//   x_out       : serial data bit (registered)
//   bit_valid   : x_out carries a data bit (registered)
//   frame_start : pulse with the first bit of each word
//   frame_done  : pulse with the last bit of each word
//   busy        : FSM is in SHIFT
module serial_bit_streamer
  import serial_bit_streamer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W     = clog2(WIDTH);
  localparam int FIRST_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam int NEXT_IDX  = (MSB_FIRST != 0) ? WIDTH - 2 : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             shift_en;
  logic [WIDTH-1:0] shreg;

  // The counter holds the number of bits still to follow the one on x_out,
  // so a new word may be taken as soon as the last bit is showing.
  assign load_ready = (state_q == ST_IDLE) || (cnt_q == '0);
  assign accept     = load_valid && load_ready;
  assign shift_en   = (state_q == ST_SHIFT) && (cnt_q != '0);

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .shift_en_i (shift_en),
    .data_i     (load_data),
    .q_o        (shreg)
  );

  // Only the bit one step behind the emitting end is read: x_out is a
  // separate flop that is loaded with the bit about to be emitted, so the
  // emitting end of the register itself is already on x_out.
  logic unused_shreg_bits;
  assign unused_shreg_bits = ^shreg;

  // x_out is loaded straight from load_data on accept so the first bit
  // appears in the cycle right after the handshake edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    x_d           = IDLE_BIT;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    if (accept) begin
      state_d       = ST_SHIFT;
      cnt_d         = CNT_W'(WIDTH - 1);
      x_d           = load_data[FIRST_IDX];
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end else if (shift_en) begin
      cnt_d        = cnt_q - 1'b1;
      x_d          = shreg[NEXT_IDX];
      bit_valid_d  = 1'b1;
      frame_done_d = (cnt_q == CNT_W'(1));
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      x_q           <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign x_out       = x_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Testbench for serial_bit_streamer. Three instances share clock and reset:
//   A : WIDTH=8, MSB first, idle level 0
//   B : WIDTH=8, LSB first, idle level 1
//   C : WIDTH=2, MSB first, idle level 0
// Each instance has a reference model: a queue of the bits it still owes,
// front entry = what x_out shows now, {bit, first-of-word, last-of-word}.
// A word can be taken whenever at most one owed bit remains.
module tb_serial_bit_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aData, bData;
  logic [1:0] cData;
  logic       aValid, bValid, cValid;
  logic       aReady, aX, aBv, aFs, aFd, aBusy;
  logic       bReady, bX, bBv, bFs, bFd, bBusy;
  logic       cReady, cX, cBv, cFs, cFd, cBusy;
  logic [5:0] aVec, bVec, cVec;

  logic [2:0] expA[$];
  logic [2:0] expB[$];
  logic [2:0] expC[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dutA (
    .clk(clk), .rst(rst), .load_data(aData), .load_valid(aValid),
    .load_ready(aReady), .x_out(aX), .bit_valid(aBv),
    .frame_start(aFs), .frame_done(aFd), .busy(aBusy));

  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dutB (
    .clk(clk), .rst(rst), .load_data(bData), .load_valid(bValid),
    .load_ready(bReady), .x_out(bX), .bit_valid(bBv),
    .frame_start(bFs), .frame_done(bFd), .busy(bBusy));

  serial_bit_streamer #(.WIDTH(2), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dutC (
    .clk(clk), .rst(rst), .load_data(cData), .load_valid(cValid),
    .load_ready(cReady), .x_out(cX), .bit_valid(cBv),
    .frame_start(cFs), .frame_done(cFd), .busy(cBusy));

  assign aVec = {aX, aBv, aFs, aFd, aBusy, aReady};
  assign bVec = {bX, bBv, bFs, bFd, bBusy, bReady};
  assign cVec = {cX, cBv, cFs, cFd, cBusy, cReady};

  // Expected {x_out, bit_valid, frame_start, frame_done, busy, load_ready}.
  function automatic logic [5:0] expVec(input logic [2:0] front, input int size, input logic idle);
    if (size == 0) return {idle, 5'b00001};
    return {front[2], 1'b1, front[1], front[0], 1'b1, size <= 1};
  endfunction

  function automatic logic [5:0] aExp();
    return expVec(expA.size() > 0 ? expA[0] : 3'b000, expA.size(), 1'b0);
  endfunction

  function automatic logic [5:0] bExp();
    return expVec(expB.size() > 0 ? expB[0] : 3'b000, expB.size(), 1'b1);
  endfunction

  function automatic logic [5:0] cExp();
    return expVec(expC.size() > 0 ? expC[0] : 3'b000, expC.size(), 1'b0);
  endfunction

  task automatic clearModels();
    expA.delete();
    expB.delete();
    expC.delete();
  endtask

  // Advance one clock: called just after a falling edge with inputs set,
  // returns at the next falling edge with the model updated.
  task automatic tick();
    bit accA, accB, accC;
    logic [7:0] dA, dB;
    logic [1:0] dC;
    accA = rst && aValid && (expA.size() <= 1);
    accB = rst && bValid && (expB.size() <= 1);
    accC = rst && cValid && (expC.size() <= 1);
    dA = aData;
    dB = bData;
    dC = cData;
    @(posedge clk);
    if (!rst) begin
      clearModels();
    end else begin
      if (expA.size() > 0) void'(expA.pop_front());
      if (expB.size() > 0) void'(expB.pop_front());
      if (expC.size() > 0) void'(expC.pop_front());
      if (accA) for (int i = 0; i < 8; i++) expA.push_back({dA[7-i], i == 0, i == 7});
      if (accB) for (int i = 0; i < 8; i++) expB.push_back({dB[i], i == 0, i == 7});
      if (accC) for (int i = 0; i < 2; i++) expC.push_back({dC[1-i], i == 0, i == 1});
    end
    @(negedge clk);
  endtask

  task automatic applyIdleInputs();
    aValid = 1'b0; bValid = 1'b0; cValid = 1'b0;
    aData = 8'h00; bData = 8'h00; cData = 2'b00;
  endtask

  task automatic test_reset();
    applyIdleInputs();
    rst = 1'b0;
    clearModels();
    repeat (2) @(negedge clk);
    vectors++;
    if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL reset_a: got %b expected %b", aVec, aExp()); end
    vectors++;
    if (bVec !== bExp()) begin miscompares++; $display("[TB] FAIL reset_b: got %b expected %b", bVec, bExp()); end
    vectors++;
    if (cVec !== cExp()) begin miscompares++; $display("[TB] FAIL reset_c: got %b expected %b", cVec, cExp()); end
    rst = 1'b1;
    tick();
    vectors++;
    if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL reset_release_a: got %b expected %b", aVec, aExp()); end
  endtask

  task automatic test_single_word();
    logic [7:0] got;
    int nbits, run, hits;
    got = '0; nbits = 0; run = 0; hits = 0;
    aData = 8'hE0; aValid = 1'b1;
    tick();
    aValid = 1'b0; aData = 8'($urandom);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL single_word cyc%0d: got %b expected %b", c, aVec, aExp()); end
      if (aBv) begin got = {got[6:0], aX}; nbits++; end
      run = (aBv && aX) ? run + 1 : 0;
      if (run == 3) hits++;
      tick();
    end
    vectors++;
    if (got !== 8'hE0 || nbits != 8) begin miscompares++; $display("[TB] FAIL single_word_stream: got %h (%0d bits) expected e0 (8 bits)", got, nbits); end
    vectors++;
    if (hits != 1) begin miscompares++; $display("[TB] FAIL single_word_111_detect: got %0d expected 1", hits); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [2];
    logic [15:0] got;
    int idx, run, maxRun;
    bit will;
    words[0] = 8'hA5; words[1] = 8'h0F;
    got = '0; idx = 0; run = 0; maxRun = 0;
    for (int c = 0; c < 40 && !(idx == 2 && expA.size() == 0); c++) begin
      aValid = (idx < 2);
      aData = (idx < 2) ? words[idx] : 8'h00;
      will = aValid && (expA.size() <= 1);
      tick();
      if (will) idx++;
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL back_to_back cyc%0d: got %b expected %b", c, aVec, aExp()); end
      if (aBv) begin got = {got[14:0], aX}; run++; if (run > maxRun) maxRun = run; end
      else run = 0;
    end
    aValid = 1'b0;
    vectors++;
    if (got !== 16'hA50F || idx != 2) begin miscompares++; $display("[TB] FAIL back_to_back_stream: got %b expected 1010010100001111", got); end
    vectors++;
    if (maxRun != 16) begin miscompares++; $display("[TB] FAIL back_to_back_gapless: got %0d expected 16", maxRun); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] got;
    got = '0;
    bData = 8'h01; bValid = 1'b1;
    tick();
    bValid = 1'b0; bData = 8'($urandom);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bVec !== bExp()) begin miscompares++; $display("[TB] FAIL lsb_first cyc%0d: got %b expected %b", c, bVec, bExp()); end
      if (bBv) got = {got[6:0], bX};
      tick();
    end
    vectors++;
    if (got !== 8'b1000_0000) begin miscompares++; $display("[TB] FAIL lsb_first_stream: got %b expected 10000000", got); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  words [2];
    logic [15:0] got;
    int idx, fsCount;
    bit will;
    words[0] = 8'h3C; words[1] = 8'h96;
    got = '0; idx = 0; fsCount = 0;
    for (int c = 0; c < 40 && !(idx == 2 && expA.size() == 0); c++) begin
      aValid = (idx == 0) || (idx == 1 && c >= 2);
      aData = (idx < 2) ? words[idx] : 8'h00;
      will = aValid && (expA.size() <= 1);
      tick();
      if (will) idx++;
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL backpressure cyc%0d: got %b expected %b", c, aVec, aExp()); end
      if (aBv) got = {got[14:0], aX};
      if (aFs) fsCount++;
      if (idx == 2) aValid = 1'b0;
    end
    aValid = 1'b0;
    vectors++;
    if (got !== 16'h3C96) begin miscompares++; $display("[TB] FAIL backpressure_stream: got %h expected 3c96", got); end
    vectors++;
    if (fsCount != 2) begin miscompares++; $display("[TB] FAIL backpressure_frames: got %0d expected 2", fsCount); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    got = '0;
    aData = 8'hFF; aValid = 1'b1;
    tick();
    aValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL mid_reset_pre cyc%0d: got %b expected %b", c, aVec, aExp()); end
      if (c < 3) tick();
    end
    #2 rst = 1'b0;
    #1;
    clearModels();
    vectors++;
    if ({aX, aBv, aFs, aFd, aBusy} !== 5'b00000) begin miscompares++; $display("[TB] FAIL mid_reset_async: got %b expected 00000", {aX, aBv, aFs, aFd, aBusy}); end
    @(negedge clk);
    vectors++;
    if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL mid_reset_held: got %b expected %b", aVec, aExp()); end
    rst = 1'b1;
    #1;
    vectors++;
    if (aReady !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", aReady); end
    aData = 8'h81; aValid = 1'b1;
    tick();
    aValid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL mid_reset_post cyc%0d: got %b expected %b", c, aVec, aExp()); end
      if (aBv) got = {got[6:0], aX};
      tick();
    end
    vectors++;
    if (got !== 8'h81) begin miscompares++; $display("[TB] FAIL mid_reset_stream: got %h expected 81", got); end
  endtask

  task automatic test_width2();
    logic [1:0] words [2];
    logic [3:0] gotX, gotFs, gotFd;
    int idx;
    bit will;
    words[0] = 2'b11; words[1] = 2'b10;
    gotX = '0; gotFs = '0; gotFd = '0; idx = 0;
    for (int c = 0; c < 12 && !(idx == 2 && expC.size() == 0); c++) begin
      cValid = (idx < 2);
      cData = (idx < 2) ? words[idx] : 2'b00;
      will = cValid && (expC.size() <= 1);
      tick();
      if (will) idx++;
      vectors++;
      if (cVec !== cExp()) begin miscompares++; $display("[TB] FAIL width2 cyc%0d: got %b expected %b", c, cVec, cExp()); end
      if (cBv) begin
        gotX = {gotX[2:0], cX}; gotFs = {gotFs[2:0], cFs}; gotFd = {gotFd[2:0], cFd};
      end
    end
    cValid = 1'b0;
    vectors++;
    if (gotX !== 4'b1110) begin miscompares++; $display("[TB] FAIL width2_stream: got %b expected 1110", gotX); end
    vectors++;
    if (gotFs !== 4'b1010 || gotFd !== 4'b0101) begin miscompares++; $display("[TB] FAIL width2_frames: got fs %b fd %b expected fs 1010 fd 0101", gotFs, gotFd); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 320; c++) begin
      if (c < 300) begin
        aValid = 1'($urandom_range(0, 1)); aData = 8'($urandom);
        bValid = 1'($urandom_range(0, 1)); bData = 8'($urandom);
        cValid = 1'($urandom_range(0, 1)); cData = 2'($urandom);
      end else begin
        applyIdleInputs();
      end
      tick();
      vectors++;
      if (aVec !== aExp()) begin miscompares++; $display("[TB] FAIL random_a cyc%0d: got %b expected %b", c, aVec, aExp()); end
      vectors++;
      if (bVec !== bExp()) begin miscompares++; $display("[TB] FAIL random_b cyc%0d: got %b expected %b", c, bVec, bExp()); end
      vectors++;
      if (cVec !== cExp()) begin miscompares++; $display("[TB] FAIL random_c cyc%0d: got %b expected %b", c, cVec, cExp()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_backpressure();
    test_reset_mid_frame();
    test_width2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_bit_streamer.md
Name: serial_bit_streamer

Overview:
- Upstream feeder for the team's Moore sequence detectors.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on a single serial line (`x_out`), which drives the detector's serial input `x`.
- Supports back-to-back words with no idle gap, and drives a defined idle bit between frames so detector state is predictable.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: level driven on `x_out` when no word is being shifted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  parallel word; sampled when the handshake completes.
- load_valid  input  1  upstream has a word on `load_data`.
- load_ready  output  1  block can accept a word this cycle (combinational).
- x_out  output  1  serial bit, registered; connects to the detector's `x`.
- bit_valid  output  1  high while `x_out` carries a data bit, registered.
- frame_start  output  1  one-cycle pulse, coincident with the first bit of each word.
- frame_done  output  1  one-cycle pulse, coincident with the last bit of each word.
- busy  output  1  high in state SHIFT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - x_out = IDLE_BIT; bit_valid, frame_start, frame_done, busy = 0.
  - Any word in flight is discarded. Outputs hold these values until the first rising edge after rst deasserts.
- States:
  - IDLE: no word loaded.
  - SHIFT: a word is being emitted; counter runs WIDTH-1 down to 0.
- Handshake:
  - load_ready = (state==IDLE) | (state==SHIFT & counter==0).
  - A word is accepted on a rising edge where load_valid & load_ready.
  - load_data need only be stable in that cycle.
  - load_valid asserted while load_ready=0 is held off; no data is lost and no error is flagged.
- Latency:
  - Word accepted at edge t: first data bit appears on x_out after edge t, i.e. in cycle t+1.
  - Each bit is held for exactly one cycle; the last bit is in cycle t+WIDTH.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT with counter==0: -> SHIFT, reloading the counter to WIDTH-1, if accept (back-to-back, zero gap); -> IDLE otherwise.
  - SHIFT with counter>0: decrement the counter and advance the shift register one position.
- Outputs:
  - bit_valid = busy during data cycles.
  - In IDLE, x_out = IDLE_BIT and bit_valid = 0.
  - For WIDTH bits, frame_start and frame_done are never high in the same cycle.
- Bit order:
  - MSB_FIRST=1: shift left and emit the MSB.
  - MSB_FIRST=0: shift right and emit the LSB.
  - Selected at elaboration time; no runtime control.
- Counter width: clog2(WIDTH) bits. No arithmetic wrap occurs because the counter is reloaded at 0, never decremented below it.
- Reset mid-frame: the partial word is dropped. After release the block is in IDLE and load_ready=1 immediately.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the clog2 helper function used for counter width, also reused by later detector variants.
- One sub-module, `shift_reg_piso`: a WIDTH-bit parallel-load shift register with load, shift enable and direction parameter.
- FSM, counter and handshake logic live in the top module.

Test Plan:
- Single word 8'hE0, MSB_FIRST=1:
  - load_valid pulsed for one cycle -> x_out = 1,1,1,0,0,0,0,0 in cycles t+1..t+8.
  - frame_start in t+1, frame_done in t+8, then x_out=0 and busy=0.
  - A chained 3-ones detector asserts y exactly once.
- Back-to-back 8'hA5 then 8'h0F, load_valid held high:
  - second word accepted at the edge where counter==0.
  - 16 consecutive bit_valid cycles, no gap.
  - x_out = 1010010100001111.
- LSB_FIRST (MSB_FIRST=0), word 8'h01 -> x_out = 1,0,0,0,0,0,0,0.
- Backpressure: load_valid held high from cycle 2 of a frame -> load_ready stays 0 until the last bit; exactly one extra word is accepted, on the counter==0 edge.
- Reset mid-frame: rst low during bit 4 of 8'hFF:
  - x_out drops to IDLE_BIT immediately (asynchronously); busy=0.
  - After release, load_ready=1 and a new word 8'h81 emits correctly.
- WIDTH=2 boundary, words 2'b11 then 2'b10 back-to-back:
  - frame_start and frame_done alternate every cycle.
  - x_out = 1,1,1,0.
